store_result_monitor: RTL and testbench

//  Synthesizable self-check stage downstream of the CPU top's data-memory store port.

---
 rtl/mon_pkg.sv | 39 +++
 rtl/sat_counter.sv | 29 ++
 rtl/store_result_monitor.sv | 117 +++++++++++
 tb/tb_store_result_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// ----------------------------------------------------------------------------
// mon_pkg
// Shared definitions for the store result monitor.
//   state_e : monitor state (2-bit encoding): RUN, PASS, FAIL, TIMEOUT
//   cls_e   : store classification: NONE, PASS_ST, ALLOW, ERROR
//   classify: combinational store classifier used by the monitor
// ----------------------------------------------------------------------------
package mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_PASS  = 2'd1,
    CLS_ALLOW = 2'd2,
    CLS_ERROR = 2'd3
  } cls_e;

  // A pass-address store with wrong data is an error, not a pass.
  function automatic cls_e classify(
    input logic        memwrite,
    input logic [31:0] dataadr,
    input logic [31:0] writedata,
    input logic [31:0] pass_addr,
    input logic [31:0] pass_data,
    input logic [31:0] allow_addr
  );
    if (!memwrite)                                          return CLS_NONE;
    else if (dataadr == pass_addr && writedata == pass_data) return CLS_PASS;
    else if (dataadr == allow_addr)                          return CLS_ALLOW;
    else                                                     return CLS_ERROR;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears q
//   inc : increment request for this cycle
//   en  : counting enabled (frozen when low)
//   q   : count value
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         en,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en && inc && (q != {W{1'b1}}))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/store_result_monitor.sv
// ----------------------------------------------------------------------------
// store_result_monitor
// Watches the CPU data-memory store port and reports the self-test outcome.
// Stores are classified as pass / allowed / error; the monitor raises sticky
// pass, fail or timeout flags and captures the first error store.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, restarts the check
//   memwrite  : store strobe, one cycle per store
//   dataadr   : store byte address
//   writedata : store data
//   done      : test finished (pass | fail | timeout)
//   pass      : finished in PASS
//   fail      : finished in FAIL
//   timeout   : finished in TIMEOUT
//   err_cnt   : error stores seen, saturating
//   store_cnt : stores seen, saturating
//   err_addr  : address of first error store
//   err_data  : data of first error store
// ----------------------------------------------------------------------------
module store_result_monitor
  import mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] ALLOW_ADDR   = 32'd80,
  parameter logic [31:0] TIMEOUT_CYC  = 32'd10000,
  parameter logic        STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [15:0] store_cnt,
  output logic [31:0] err_addr,
  output logic [31:0] err_data
);

  state_e      state;
  cls_e        cls;
  logic [31:0] cyc;
  logic        running;

  // NOTE: combinational outputs are assigned on every path (here via a single
  // function call), so no latch can be inferred.
  always_comb begin
    cls = classify(memwrite, dataadr, writedata, PASS_ADDR, PASS_DATA, ALLOW_ADDR);
  end

  // Counters freeze once any terminal state is reached.
  assign running = (state == ST_RUN);

  sat_counter #(.W(16)) u_store_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cls != CLS_NONE),
    .en  (running),
    .q   (store_cnt)
  );

  sat_counter #(.W(8)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cls == CLS_ERROR),
    .en  (running),
    .q   (err_cnt)
  );

  // Priority inside RUN: pass store beats everything (it wins over the
  // terminal count), then a stopping error, then the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      cyc      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else if (state == ST_RUN) begin
      cyc <= cyc + 32'd1;

      // err_cnt saturates at 255 and never returns to zero, so zero means
      // this is the first error store of the run.
      if (cls == CLS_ERROR && err_cnt == 8'd0) begin
        err_addr <= dataadr;
        err_data <= writedata;
      end

      if (cls == CLS_PASS) begin
        done <= 1'b1;
        if (err_cnt == 8'd0) begin
          state <= ST_PASS;
          pass  <= 1'b1;
        end else begin
          state <= ST_FAIL;
          fail  <= 1'b1;
        end
      end else if (cls == CLS_ERROR && STOP_ON_FAIL) begin
        state <= ST_FAIL;
        done  <= 1'b1;
        fail  <= 1'b1;
      end else if (cyc == TIMEOUT_CYC - 32'd1) begin
        state   <= ST_TIMEOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_result_monitor.sv
// ----------------------------------------------------------------------------
// tb_store_result_monitor
// Three monitor instances share clock, reset and store stimulus:
//   inst 0 : default parameters (STOP_ON_FAIL=0, TIMEOUT_CYC=10000)
//   inst 1 : STOP_ON_FAIL=1
//   inst 2 : TIMEOUT_CYC=20
// Expected output snapshots are pushed to a scoreboard queue as stimulus is
// driven and popped/compared once the DUT has taken the clock edge.
// ----------------------------------------------------------------------------
module tb_store_result_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic [2:0]  done, pass, fail, timeout;
  logic [7:0]  err_cnt   [3];
  logic [15:0] store_cnt [3];
  logic [31:0] err_addr  [3];
  logic [31:0] err_data  [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          inst;
    logic        done, pass, fail, timeout;
    logic [7:0]  ec;
    logic [15:0] sc;
    logic [31:0] ea, ed;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  store_result_monitor u_dut0 (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(timeout[0]),
    .err_cnt(err_cnt[0]), .store_cnt(store_cnt[0]), .err_addr(err_addr[0]), .err_data(err_data[0])
  );

  store_result_monitor #(.STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(timeout[1]),
    .err_cnt(err_cnt[1]), .store_cnt(store_cnt[1]), .err_addr(err_addr[1]), .err_data(err_data[1])
  );

  store_result_monitor #(.TIMEOUT_CYC(32'd20)) u_dut2 (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[2]), .pass(pass[2]), .fail(fail[2]), .timeout(timeout[2]),
    .err_cnt(err_cnt[2]), .store_cnt(store_cnt[2]), .err_addr(err_addr[2]), .err_data(err_data[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int inst,
                            input logic d, input logic p, input logic f, input logic t,
                            input logic [7:0] ec, input logic [15:0] sc,
                            input logic [31:0] ea, input logic [31:0] ed);
    exp_t e;
    e.tag = tag; e.inst = inst;
    e.done = d; e.pass = p; e.fail = f; e.timeout = t;
    e.ec = ec; e.sc = sc; e.ea = ea; e.ed = ed;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the addressed instance.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".done"},      32'(done[e.inst]),      32'(e.done));
      check({e.tag, ".pass"},      32'(pass[e.inst]),      32'(e.pass));
      check({e.tag, ".fail"},      32'(fail[e.inst]),      32'(e.fail));
      check({e.tag, ".timeout"},   32'(timeout[e.inst]),   32'(e.timeout));
      check({e.tag, ".err_cnt"},   32'(err_cnt[e.inst]),   32'(e.ec));
      check({e.tag, ".store_cnt"}, 32'(store_cnt[e.inst]), 32'(e.sc));
      check({e.tag, ".err_addr"},  err_addr[e.inst],       e.ea);
      check({e.tag, ".err_data"},  err_data[e.inst],       e.ed);
    end
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, return at
  // the next falling edge with outputs settled.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0);
  endtask

  // One rising edge with rst high; returns at a falling edge with rst low.
  task automatic pulse_reset();
    rst      = 1'b1;
    memwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Reset state on all instances.
    pulse_reset();
    for (int i = 0; i < 3; i++)
      expect_out($sformatf("reset%0d", i), i, 0, 0, 0, 0, 8'd0, 16'd0, 32'd0, 32'd0);
    drain();

    // 1: allowed store then pass store.
    expect_out("t1_allow", 0, 0, 0, 0, 0, 8'd0, 16'd1, 32'd0, 32'd0);
    step(1'b1, 32'd80, 32'd5);
    expect_out("t1_pass", 0, 1, 1, 0, 0, 8'd0, 16'd2, 32'd0, 32'd0);
    step(1'b1, 32'd84, 32'd7);

    // 2: error then pass store, no stop on fail.
    pulse_reset();
    expect_out("t2_err", 0, 0, 0, 0, 0, 8'd1, 16'd1, 32'd88, 32'd1);
    step(1'b1, 32'd88, 32'd1);
    expect_out("t2_fail", 0, 1, 0, 1, 0, 8'd1, 16'd2, 32'd88, 32'd1);
    step(1'b1, 32'd84, 32'd7);

    // 3: wrong data at pass address; stop-on-fail ends at once, default keeps running.
    pulse_reset();
    expect_out("t3_stop", 1, 1, 0, 1, 0, 8'd1, 16'd1, 32'd84, 32'd6);
    expect_out("t3_run",  0, 0, 0, 0, 0, 8'd1, 16'd1, 32'd84, 32'd6);
    step(1'b1, 32'd84, 32'd6);
    expect_out("t3_frozen", 1, 1, 0, 1, 0, 8'd1, 16'd1, 32'd84, 32'd6);
    step(1'b1, 32'd84, 32'd7);

    // 4: timeout on the 20th edge after reset release.
    pulse_reset();
    idle(19);
    expect_out("t4_pre", 2, 0, 0, 0, 0, 8'd0, 16'd0, 32'd0, 32'd0);
    drain();
    expect_out("t4_to", 2, 1, 0, 0, 1, 8'd0, 16'd0, 32'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0);
    expect_out("t4_to_hold", 2, 1, 0, 0, 1, 8'd0, 16'd0, 32'd0, 32'd0);
    step(1'b1, 32'd84, 32'd7);
    // Pass store on the terminal-count edge wins over the timeout.
    pulse_reset();
    idle(19);
    expect_out("t4_store_wins", 2, 1, 1, 0, 0, 8'd0, 16'd1, 32'd0, 32'd0);
    step(1'b1, 32'd84, 32'd7);
    expect_out("t4_ignored", 2, 1, 1, 0, 0, 8'd0, 16'd1, 32'd0, 32'd0);
    step(1'b1, 32'd88, 32'd3);

    // 5: reset in the middle of a run.
    pulse_reset();
    step(1'b1, 32'd100, 32'd11);
    step(1'b1, 32'd104, 32'd12);
    expect_out("t5_errs", 0, 0, 0, 0, 0, 8'd3, 16'd3, 32'd100, 32'd11);
    step(1'b1, 32'd108, 32'd13);
    pulse_reset();
    expect_out("t5_reset", 0, 0, 0, 0, 0, 8'd0, 16'd0, 32'd0, 32'd0);
    drain();
    expect_out("t5_pass", 0, 1, 1, 0, 0, 8'd0, 16'd1, 32'd0, 32'd0);
    step(1'b1, 32'd84, 32'd7);

    // 6: err_cnt saturation keeps the monitor running.
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      if (i == 254)
        expect_out("t6_254", 0, 0, 0, 0, 0, 8'd255, 16'd255, 32'd92, 32'd100);
      if (i == 299)
        expect_out("t6_sat", 0, 0, 0, 0, 0, 8'd255, 16'd300, 32'd92, 32'd100);
      step(1'b1, 32'd92, 32'(100 + i));
    end
    // Error count at 255 still turns a later pass store into a fail.
    expect_out("t6_fail", 0, 1, 0, 1, 0, 8'd255, 16'd301, 32'd92, 32'd100);
    step(1'b1, 32'd84, 32'd7);

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
